i4002_initiator: RTL and testbench
==================================

I4002_INITIATOR -- requirements
Module: i4002_initiator

Interface
REQ-001 Parameter: QTR, default 2, number of sysclk ticks per quarter-subcycle; one subcycle SHALL be 4*QTR ticks.
REQ-002 Port: sysclk  in  1  system clock; all logic rising-edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: clk1, clk2, sync, cm  out  1 each  MCS-4 phase clocks, cycle sync and command line.
REQ-005 Port: mcs_reset  out  1  synchronous active-high MCS-4 bus reset to responders.
REQ-006 Port: data  inout (tri)  4  MCS-4 bidirectional data bus.
REQ-007 Port: req_valid  in  1; req_ready  out  1; req_op  in  3 (0 WRM, 1 WMP, 2 WRX, 3 RDM, 4 RDX, 5-7 reserved); req_chip  in  2; req_reg  in  2; req_char  in  4; req_idx  in  2 (status index for WRX/RDX); req_wdata  in  4.
REQ-008 Port: done  out  1  one-sysclk completion pulse; rsp_rdata  out  4  read result.

Function
REQ-009 A tick counter (0..4*QTR-1) and subcycle counter (0..7 = A1,A2,A3,M1,M2,X1,X2,X3) SHALL free-run whenever reset_n is high, wrapping X3->A1.
REQ-010 clk1 SHALL be high for ticks 0..QTR-1 and clk2 for ticks 2*QTR..3*QTR-1 of every subcycle; both low otherwise.
REQ-011 sync SHALL be high for the whole X3 subcycle and low elsewhere.
REQ-012 data and cm SHALL change only at tick 0 of a subcycle.
REQ-013 Instruction cycle types: NOP (M1=0x0, M2=0x0, cm low), SRC, IO; A1-A3 SHALL drive 0x0, X1 SHALL drive 0x0 except in read IO cycles.
REQ-014 SRC cycle: M1=0x2, M2=0x1, cm low in M2; X2 drives {req_chip,req_reg} with cm high; X3 drives req_char, cm low.
REQ-015 IO cycle: M1=0xE; M2 drives OPA with cm high; OPA = 0x0 WRM, 0x1 WMP, {2'b01,req_idx} WRX, 0x8 RDM, {2'b11,req_idx} RDX.
REQ-016 Write IO cycles SHALL drive req_wdata during X2 and X3.
REQ-017 Read IO cycles SHALL release data (z) from tick 0 of X1 to tick 0 of X3, and capture data into rsp_rdata on the last clk2-high tick (3*QTR-1) of X2.
REQ-018 FSM states: BUSRST, IDLE, SRC, IO. BUSRST->IDLE after 32 complete instruction cycles; IDLE->SRC and IO->SRC on handshake; SRC->IO at X3 end; IO->IDLE at X3 end with no handshake.
REQ-019 req_ready SHALL be high only on the last tick of X3 while state is IDLE or IO; a transfer occurs when req_valid and req_ready are both high; request fields are registered then.
REQ-020 The SRC cycle SHALL begin at the A1 immediately following the handshake; the IO cycle SHALL immediately follow it; back-to-back requests SHALL produce no NOP cycle.
REQ-021 done SHALL pulse for one sysclk at tick 0 of X3 of the IO cycle; rsp_rdata SHALL hold until the next read capture and is unchanged by write ops.
REQ-022 Reserved ops SHALL perform the SRC cycle, then a NOP cycle in place of IO, then pulse done with rsp_rdata unchanged.
REQ-023 In IDLE and BUSRST, NOP cycles SHALL be emitted continuously.

Reset
REQ-024 While reset_n is low: clk1, clk2, sync, cm, req_ready, done low; mcs_reset high; data released; rsp_rdata 0x0; counters zero (A1, tick 0); state BUSRST.
REQ-025 After reset_n rises, mcs_reset SHALL stay high for 32 instruction cycles (256 subcycles), falling at tick 0 of the following A1.
REQ-026 Reset assertion mid-transaction SHALL abort immediately with no done pulse and restart the BUSRST sequence.

Verification
REQ-027 Release reset, QTR=2 -> mcs_reset high 2048 sysclk, req_ready first high on last tick of X3 of cycle 33.
REQ-028 WRM chip 2, reg 1, char 0xA, wdata 0x5 -> SRC: M1 0x2, M2 0x1, X2 0x9 with cm high, X3 0xA; IO: M1 0xE, M2 0x0 with cm high, X2 0x5; done pulse.
REQ-029 RDM with responder model driving 0x7 during X2 -> bus released X1-X2, rsp_rdata 0x7 at done.
REQ-030 RDX idx 3 then WRX idx 1 back-to-back -> OPA 0xF then 0x5, no NOP cycle between transactions.
REQ-031 reset_n low during IO X2 of a WRM -> all outputs at reset values within the same sysclk, no done pulse, mcs_reset high.
REQ-032 req_op 6 -> SRC cycle, NOP cycle with cm low in M2, done pulse, rsp_rdata unchanged.

Source files
------------

// File: rtl/i4002_initiator.sv
// MCS-4 bus initiator: generates clk1/clk2/sync and issues one SRC + IO instruction-cycle
// pair per request toward 4002 RAM responders, with bus-reset sequencing after reset.
module i4002_initiator #(
    parameter int QTR = 2
) (
    input  logic       sysclk,
    input  logic       reset_n,
    output logic       clk1,
    output logic       clk2,
    output logic       sync,
    output logic       cm,
    output logic       mcs_reset,
    inout  tri   [3:0] data,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [1:0] req_chip,
    input  logic [1:0] req_reg,
    input  logic [3:0] req_char,
    input  logic [1:0] req_idx,
    input  logic [3:0] req_wdata,
    output logic       done,
    output logic [3:0] rsp_rdata,
    output logic [1:0] dbg_state
);

    localparam int TPS = 4 * QTR;
    localparam int TW  = $clog2(TPS);
    localparam logic [TW-1:0] T_LAST   = TW'(TPS - 1);
    localparam logic [TW-1:0] T_C1_END = TW'(QTR);
    localparam logic [TW-1:0] T_C2_BEG = TW'(2 * QTR);
    localparam logic [TW-1:0] T_C2_END = TW'(3 * QTR);
    localparam logic [TW-1:0] T_CAP    = TW'(3 * QTR - 1);

    localparam logic [2:0] S_M1 = 3'd3, S_M2 = 3'd4, S_X1 = 3'd5, S_X2 = 3'd6, S_X3 = 3'd7;
    localparam logic [2:0] OP_WMP = 3'd1, OP_WRX = 3'd2, OP_RDM = 3'd3, OP_RDX = 3'd4;

    typedef enum logic [1:0] {BUSRST = 2'd0, IDLE = 2'd1, SRC = 2'd2, IO = 2'd3} state_t;

    state_t        state, state_n;
    logic          run;
    logic [TW-1:0] tick, tick_n;
    logic [2:0]    sub, sub_n;
    logic [4:0]    cyc_cnt;
    logic [2:0]    op_q;
    logic [1:0]    chip_q, reg_sel_q, idx_q;
    logic [3:0]    char_q, wdata_q;
    logic [3:0]    data_q, opa, bus_d;
    logic          data_oe, bus_oe, bus_cm;
    logic          a1_entry, hs, op_read, op_write, op_ok;

    assign data      = data_oe ? data_q : 4'bz;
    assign dbg_state = state;

    // Handshake: req_ready is high only on the final tick of X3 in IDLE/IO; a request is
    // taken on the sysclk edge where req_valid and req_ready are both high, which is also
    // the edge that starts the next A1, so the SRC cycle follows with no gap.
    assign a1_entry = run && (sub == S_X3) && (tick == T_LAST);
    assign hs       = a1_entry && req_valid && req_ready;
    assign op_read  = (op_q == OP_RDM) || (op_q == OP_RDX);
    assign op_write = (op_q <= OP_WRX);
    assign op_ok    = (op_q <= OP_RDX);

    // The first edge after reset release only arms the counters so tick 0 of A1 is full length.
    always_comb begin
        tick_n = '0;
        sub_n  = '0;
        if (run) begin
            if (tick == T_LAST) begin
                tick_n = '0;
                sub_n  = sub + 3'd1;
            end else begin
                tick_n = tick + TW'(1);
                sub_n  = sub;
            end
        end
    end

    always_comb begin
        state_n = state;
        if (a1_entry) begin
            case (state)
                BUSRST:  if (cyc_cnt == 5'd31) state_n = IDLE;
                IDLE:    if (hs) state_n = SRC;
                SRC:     state_n = IO;
                IO:      state_n = hs ? SRC : IDLE;
                default: state_n = BUSRST;
            endcase
        end
    end

    always_comb begin
        opa = 4'h0;
        case (op_q)
            OP_WMP:  opa = 4'h1;
            OP_WRX:  opa = {2'b01, idx_q};
            OP_RDM:  opa = 4'h8;
            OP_RDX:  opa = {2'b11, idx_q};
            default: opa = 4'h0;
        endcase
    end

    // Bus content for the subcycle being entered; A1..A3 and NOP subcycles drive 0.
    always_comb begin
        bus_d  = 4'h0;
        bus_oe = 1'b1;
        bus_cm = 1'b0;
        case (sub_n)
            S_M1: begin
                if (state == SRC) bus_d = 4'h2;
                else if (state == IO && op_ok) bus_d = 4'hE;
            end
            S_M2: begin
                if (state == SRC) bus_d = 4'h1;
                else if (state == IO && op_ok) begin
                    bus_d  = opa;
                    bus_cm = 1'b1;
                end
            end
            S_X1: if (state == IO && op_read) bus_oe = 1'b0;
            S_X2: begin
                if (state == SRC) begin
                    bus_d  = {chip_q, reg_sel_q};
                    bus_cm = 1'b1;
                end else if (state == IO && op_write) bus_d = wdata_q;
                else if (state == IO && op_read) bus_oe = 1'b0;
            end
            S_X3: begin
                if (state == SRC) bus_d = char_q;
                else if (state == IO && op_write) bus_d = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            tick      <= '0;
            sub       <= '0;
            state     <= BUSRST;
            cyc_cnt   <= '0;
            clk1      <= 1'b0;
            clk2      <= 1'b0;
            sync      <= 1'b0;
            cm        <= 1'b0;
            mcs_reset <= 1'b1;
            req_ready <= 1'b0;
            done      <= 1'b0;
            data_q    <= '0;
            data_oe   <= 1'b0;
            rsp_rdata <= '0;
            op_q      <= '0;
            chip_q    <= '0;
            reg_sel_q <= '0;
            idx_q     <= '0;
            char_q    <= '0;
            wdata_q   <= '0;
        end else begin
            run   <= 1'b1;
            tick  <= tick_n;
            sub   <= sub_n;
            state <= state_n;
            if (a1_entry && state == BUSRST) cyc_cnt <= cyc_cnt + 5'd1;
            clk1      <= (tick_n < T_C1_END);
            clk2      <= (tick_n >= T_C2_BEG) && (tick_n < T_C2_END);
            sync      <= (sub_n == S_X3);
            mcs_reset <= (state_n == BUSRST);
            req_ready <= (sub_n == S_X3) && (tick_n == T_LAST) && (state_n == IDLE || state_n == IO);
            done      <= (sub_n == S_X3) && (tick_n == '0) && (state_n == IO);
            if (tick_n == '0) begin
                data_q  <= bus_d;
                data_oe <= bus_oe;
                cm      <= bus_cm;
            end
            if (hs) begin
                op_q      <= req_op;
                chip_q    <= req_chip;
                reg_sel_q <= req_reg;
                idx_q     <= req_idx;
                char_q    <= req_char;
                wdata_q   <= req_wdata;
            end
            if (run && state == IO && op_read && sub == S_X2 && tick == T_CAP) rsp_rdata <= data;
        end
    end

endmodule

// File: tb/tb_i4002_initiator.sv
// Directed bench for i4002_initiator: bus-reset timing, SRC/IO frames per op,
// read capture, back-to-back requests, reserved op and mid-transaction reset.
module tb_i4002_initiator;
    logic       sysclk = 1'b0;
    logic       reset_n;
    logic       clk1, clk2, sync, cm, mcs_reset, req_ready, done;
    tri   [3:0] data;
    logic       req_valid;
    logic [2:0] req_op;
    logic [1:0] req_chip, req_reg, req_idx, dbg_state;
    logic [3:0] req_char, req_wdata, rsp_rdata;
    logic       tb_oe;
    logic [3:0] tb_d;

    int n_checks, n_fail, wait_cnt;
    logic [3:0] d_k [128];
    logic       cm_k [128];
    logic       done_k [128];
    logic       clk1_k [128];
    logic       clk2_k [128];
    logic       sync_k [128];
    logic [3:0] rsp_at_done;

    // released bus lines read back as 1
    pullup (data[0]);
    pullup (data[1]);
    pullup (data[2]);
    pullup (data[3]);
    assign data = tb_oe ? tb_d : 4'bz;

    always #5 sysclk = ~sysclk;

    i4002_initiator #(.QTR(2)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .clk1(clk1), .clk2(clk2), .sync(sync), .cm(cm),
        .mcs_reset(mcs_reset), .data(data), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_chip(req_chip), .req_reg(req_reg), .req_char(req_char),
        .req_idx(req_idx), .req_wdata(req_wdata), .done(done), .rsp_rdata(rsp_rdata),
        .dbg_state(dbg_state)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for the handshake, then record the SRC and IO cycles
    // (k = 0 is A1 tick 0 of the SRC cycle). A responder drives resp during IO X2 for reads.
    task automatic run_txn(input logic [2:0] op, input logic [1:0] chip, input logic [1:0] rg,
                           input logic [3:0] ch, input logic [1:0] idx, input logic [3:0] wd,
                           input logic [3:0] resp);
        bit is_read;
        is_read   = (op == 3'd3) || (op == 3'd4);
        req_valid = 1'b1;
        req_op    = op;
        req_chip  = chip;
        req_reg   = rg;
        req_char  = ch;
        req_idx   = idx;
        req_wdata = wd;
        wait_cnt  = 0;
        while (!req_ready && wait_cnt < 200) begin
            @(negedge sysclk);
            wait_cnt++;
        end
        check_eq("hs_ready", {63'b0, req_ready}, 64'd1);
        @(negedge sysclk);
        req_valid = 1'b0;
        for (int k = 0; k < 128; k++) begin
            if (k > 0) @(negedge sysclk);
            d_k[k]    = data;
            cm_k[k]   = cm;
            done_k[k] = done;
            clk1_k[k] = clk1;
            clk2_k[k] = clk2;
            sync_k[k] = sync;
            if (k == 120) rsp_at_done = rsp_rdata;
            tb_oe = is_read && (k >= 112) && (k <= 118);
            tb_d  = resp;
        end
    endtask

    task automatic check_frame(input string tag, input logic [63:0] exp_d, input logic [15:0] exp_cm);
        logic [63:0] od;
        logic [15:0] oc;
        int dc, dp;
        for (int s = 0; s < 16; s++) begin
            od[4*s +: 4] = d_k[8*s + 3];
            oc[s]        = cm_k[8*s + 3];
        end
        dc = 0;
        dp = -1;
        for (int k = 0; k < 128; k++) begin
            if (done_k[k]) begin
                dc++;
                if (dp < 0) dp = k;
            end
        end
        check_eq({tag, "_bus"}, od, exp_d);
        check_eq({tag, "_cm"}, {48'b0, oc}, {48'b0, exp_cm});
        check_eq({tag, "_done_n"}, 64'(dc), 64'd1);
        check_eq({tag, "_done_at"}, 64'(dp), 64'd120);
    endtask

    initial begin
        int hi_cnt, rdy_cnt, chg, dn, lo;
        logic [7:0]  p1, p2;
        logic [63:0] ps;
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_chip  = '0;
        req_reg   = '0;
        req_char  = '0;
        req_idx   = '0;
        req_wdata = '0;
        tb_oe     = 1'b0;
        tb_d      = '0;

        repeat (3) @(negedge sysclk);
        check_eq("rst_ctl", {57'b0, clk1, clk2, sync, cm, req_ready, done, mcs_reset}, 64'b0000001);
        check_eq("rst_data", {60'b0, data}, 64'hF);
        check_eq("rst_rdata", {60'b0, rsp_rdata}, 64'h0);
        check_eq("rst_state", {62'b0, dbg_state}, 64'h0);

        #1 reset_n = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sysclk);
            if (mcs_reset) hi_cnt++;
            else break;
        end
        check_eq("mcs_reset_len", 64'(hi_cnt), 64'd2048);
        rdy_cnt = 0;
        while (!req_ready && rdy_cnt < 200) begin
            @(negedge sysclk);
            rdy_cnt++;
        end
        check_eq("first_ready", 64'(rdy_cnt), 64'd63);

        // WRM chip 2 reg 1 char A wdata 5
        run_txn(3'd0, 2'd2, 2'd1, 4'hA, 2'd0, 4'h5, 4'h0);
        check_frame("wrm", 64'h5500E000_A9012000, 16'h1040);
        check_eq("wrm_rdata", {60'b0, rsp_rdata}, 64'h0);
        for (int k = 0; k < 8; k++) begin
            p1[k] = clk1_k[k];
            p2[k] = clk2_k[k];
        end
        for (int k = 0; k < 64; k++) ps[k] = sync_k[k];
        check_eq("clk1_phase", {56'b0, p1}, 64'h03);
        check_eq("clk2_phase", {56'b0, p2}, 64'h30);
        check_eq("sync_phase", ps, 64'hFF00_0000_0000_0000);
        chg = 0;
        for (int k = 1; k < 128; k++)
            if ((k % 8) != 0 && (d_k[k] !== d_k[k-1] || cm_k[k] !== cm_k[k-1])) chg++;
        check_eq("bus_tick0_only", 64'(chg), 64'd0);

        // RDM chip 1 reg 0 char 3, responder returns 7
        run_txn(3'd3, 2'd1, 2'd0, 4'h3, 2'd0, 4'h0, 4'h7);
        check_eq("rdm_gap", 64'(wait_cnt), 64'd0);
        check_frame("rdm", 64'h07F8E000_34012000, 16'h1040);
        check_eq("rdm_rdata", {60'b0, rsp_at_done}, 64'h7);

        // RDX idx 3 then WRX idx 1 back-to-back
        run_txn(3'd4, 2'd3, 2'd2, 4'h0, 2'd3, 4'h0, 4'hC);
        check_frame("rdx", 64'h0CFFE000_0E012000, 16'h1040);
        check_eq("rdx_rdata", {60'b0, rsp_at_done}, 64'hC);
        run_txn(3'd2, 2'd0, 2'd3, 4'h5, 2'd1, 4'h3, 4'h0);
        check_eq("wrx_gap", 64'(wait_cnt), 64'd0);
        check_frame("wrx", 64'h3305E000_53012000, 16'h1040);
        check_eq("wrx_rdata", {60'b0, rsp_rdata}, 64'hC);

        // reserved op 6: SRC then NOP, done, rsp_rdata held
        run_txn(3'd6, 2'd1, 2'd1, 4'h9, 2'd0, 4'h0, 4'h0);
        check_frame("rsv", 64'h00000000_95012000, 16'h0040);
        check_eq("rsv_rdata", {60'b0, rsp_rdata}, 64'hC);

        // reset during IO X2 of a WRM
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_chip  = 2'd2;
        req_reg   = 2'd1;
        req_char  = 4'hA;
        req_wdata = 4'h5;
        wait_cnt  = 0;
        while (!req_ready && wait_cnt < 200) begin
            @(negedge sysclk);
            wait_cnt++;
        end
        @(negedge sysclk);
        req_valid = 1'b0;
        repeat (116) @(negedge sysclk);
        check_eq("pre_abort", {59'b0, clk2, data}, {59'b0, 1'b1, 4'h5});
        #1 reset_n = 1'b0;
        #1;
        check_eq("abort_ctl", {57'b0, clk1, clk2, sync, cm, req_ready, done, mcs_reset}, 64'b0000001);
        check_eq("abort_data", {60'b0, data}, 64'hF);
        check_eq("abort_rdata", {60'b0, rsp_rdata}, 64'h0);
        check_eq("abort_state", {62'b0, dbg_state}, 64'h0);
        repeat (3) @(negedge sysclk);
        #1 reset_n = 1'b1;
        dn = 0;
        lo = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sysclk);
            if (done) dn++;
            if (!mcs_reset) lo++;
        end
        check_eq("abort_no_done", 64'(dn), 64'd0);
        check_eq("abort_busrst", 64'(lo), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
